// File: rtl/iosram_out_sequencer_pkg.sv
// Shared types and constants for the IO-output SRAM sequencer.
package iosram_out_sequencer_pkg;

  localparam int RESOURCE_INSTR_WIDTH  = 27;
  localparam int INSTR_OPCODE_BITWIDTH = 3;
  localparam int BULK_BITWIDTH         = 256;
  localparam int IO_ADDR_WIDTH         = 16;
  localparam int SRAM_ADDR_WIDTH       = 6;
  localparam int DEPTH                 = 64;
  localparam int PAYLOAD_WIDTH         = RESOURCE_INSTR_WIDTH - INSTR_OPCODE_BITWIDTH;
  localparam int CNT_WIDTH             = 6;

  localparam logic [INSTR_OPCODE_BITWIDTH-1:0] OP_REP = 3'd0;
  localparam logic [INSTR_OPCODE_BITWIDTH-1:0] OP_DSU = 3'd6;

  localparam logic [1:0] PORT_IO = 2'd0;
  localparam logic [1:0] PORT_WR = 2'd2;
  localparam logic [1:0] PORT_RD = 2'd3;

  typedef struct packed {
    logic                     rsvd_hi;
    logic [IO_ADDR_WIDTH-1:0] init_addr;
    logic [1:0]               port;
    logic [4:0]               rsvd_lo;
  } dsu_t;

  typedef struct packed {
    logic [1:0]           port;
    logic [3:0]           level;
    logic [CNT_WIDTH-1:0] iter;
    logic [CNT_WIDTH-1:0] step;
    logic [CNT_WIDTH-1:0] delay;
  } rep_t;

  // Programmed configuration for all three address generators.
  typedef struct packed {
    logic [SRAM_ADDR_WIDTH-1:0] wr_init;
    logic [CNT_WIDTH-1:0]       wr_iter;
    logic [CNT_WIDTH-1:0]       wr_step;
    logic [CNT_WIDTH-1:0]       wr_delay;
    logic [SRAM_ADDR_WIDTH-1:0] rd_init;
    logic [CNT_WIDTH-1:0]       rd_iter;
    logic [CNT_WIDTH-1:0]       rd_step;
    logic [CNT_WIDTH-1:0]       rd_delay;
    logic [IO_ADDR_WIDTH-1:0]   io_init;
    logic [CNT_WIDTH-1:0]       io_step;
  } cfg_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_BEAT = 2'd1,
    W_GAP  = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_RD   = 2'd1,
    D_XFER = 2'd2,
    D_GAP  = 2'd3
  } dr_state_e;

  function automatic dsu_t unpack_dsu(input logic [PAYLOAD_WIDTH-1:0] payload);
    return dsu_t'(payload);
  endfunction

  function automatic rep_t unpack_rep(input logic [PAYLOAD_WIDTH-1:0] payload);
    return rep_t'(payload);
  endfunction

endpackage

// File: rtl/iosram_out_agu.sv
// Single-level address generator: addr = init + k*step, k = 0..iter.
// 'last' is high while the current address is the final one of the run.
module iosram_out_agu #(
  parameter int W  = 6,
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          advance,
  input  logic [W-1:0]  init,
  input  logic [W-1:0]  step,
  input  logic [CW-1:0] iter,
  output logic [W-1:0]  addr,
  output logic          last
);

  logic [W-1:0]  addr_q,   addr_d;
  logic [W-1:0]  step_q,   step_d;
  logic [CW-1:0] remain_q, remain_d;

  // Load a new run or step to the next address; remaining beats count down.
  always_comb begin
    addr_d   = addr_q;
    step_d   = step_q;
    remain_d = remain_q;
    if (load) begin
      addr_d   = init;
      step_d   = step;
      remain_d = iter;
    end else if (advance) begin
      addr_d = addr_q + step_q;
      if (remain_q != '0) remain_d = remain_q - CW'(1);
    end
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      step_q   <= '0;
      remain_q <= '0;
    end else begin
      addr_q   <= addr_d;
      step_q   <= step_d;
      remain_q <= remain_d;
    end
  end

  assign addr = addr_q;
  assign last = (remain_q == '0);

endmodule

// File: rtl/iosram_out_sequencer.sv
// IO-output SRAM sequencer: fabric bulk data is written into a 64x256 buffer
// by the write channel and drained to the IO write interface by the drain
// channel, which honours io_ready_out backpressure.
//
// state  | meaning
// W_IDLE | write channel waiting for activate[2]
// W_BEAT | writing bulk_data_in to sram[wr_addr] this cycle
// W_GAP  | idle cycles between write beats
// D_IDLE | drain channel waiting for activate[3]
// D_RD   | SRAM read issued, data lands in the read register
// D_XFER | IO beat presented, held until io_ready_out
// D_GAP  | idle cycles between drain beats
module iosram_out_sequencer
  import iosram_out_sequencer_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            instr_en,
  input  logic [RESOURCE_INSTR_WIDTH-1:0] instr,
  input  logic [3:0]                      activate,
  input  logic [BULK_BITWIDTH-1:0]        bulk_data_in,
  output logic                            io_en_out,
  output logic [IO_ADDR_WIDTH-1:0]        io_addr_out,
  output logic [BULK_BITWIDTH-1:0]        io_data_out,
  input  logic                            io_ready_out,
  output logic [1:0]                      busy
);

  logic [INSTR_OPCODE_BITWIDTH-1:0] opcode;
  dsu_t dsu;
  rep_t rep;
  cfg_t cfg_q, cfg_d;

  wr_state_e            wr_state_q, wr_state_d;
  logic [CNT_WIDTH-1:0] wr_delay_q, wr_delay_d;
  logic [CNT_WIDTH-1:0] wr_gap_q,   wr_gap_d;
  logic                 wr_load, wr_adv, wr_last;
  logic [SRAM_ADDR_WIDTH-1:0] wr_addr;

  dr_state_e            dr_state_q, dr_state_d;
  logic [CNT_WIDTH-1:0] dr_delay_q, dr_delay_d;
  logic [CNT_WIDTH-1:0] dr_gap_q,   dr_gap_d;
  logic                 dr_load, dr_adv, dr_last, rd_last, io_last;
  logic [SRAM_ADDR_WIDTH-1:0] rd_addr;
  logic [IO_ADDR_WIDTH-1:0]   io_addr;

  logic                     sram_we, sram_re;
  logic [BULK_BITWIDTH-1:0] mem_q [DEPTH];
  logic [BULK_BITWIDTH-1:0] rdata_q, rdata_d;

  logic unused_bits;

  assign opcode = instr[RESOURCE_INSTR_WIDTH-1 -: INSTR_OPCODE_BITWIDTH];
  assign dsu    = unpack_dsu(instr[PAYLOAD_WIDTH-1:0]);
  assign rep    = unpack_rep(instr[PAYLOAD_WIDTH-1:0]);
  assign unused_bits = ^{activate[1:0], dsu.rsvd_hi, dsu.rsvd_lo};

  // Decode DSU/REP into the config registers; only level-0 REP is honoured.
  always_comb begin
    cfg_d = cfg_q;
    if (instr_en) begin
      if (opcode == OP_DSU) begin
        case (dsu.port)
          PORT_WR: cfg_d.wr_init = dsu.init_addr[SRAM_ADDR_WIDTH-1:0];
          PORT_RD: cfg_d.rd_init = dsu.init_addr[SRAM_ADDR_WIDTH-1:0];
          PORT_IO: cfg_d.io_init = dsu.init_addr;
          default: ;
        endcase
      end else if (opcode == OP_REP && rep.level == 4'd0) begin
        case (rep.port)
          PORT_WR: begin
            cfg_d.wr_iter  = rep.iter;
            cfg_d.wr_step  = rep.step;
            cfg_d.wr_delay = rep.delay;
          end
          PORT_RD: begin
            cfg_d.rd_iter  = rep.iter;
            cfg_d.rd_step  = rep.step;
            cfg_d.rd_delay = rep.delay;
          end
          PORT_IO: cfg_d.io_step = rep.step;
          default: ;
        endcase
      end
    end
  end

  // Write channel next-state: one beat, optional gap, repeat until last.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_delay_d = wr_delay_q;
    wr_gap_d   = wr_gap_q;
    wr_load    = 1'b0;
    wr_adv     = 1'b0;
    sram_we    = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (activate[PORT_WR]) begin
          wr_load    = 1'b1;
          wr_delay_d = cfg_q.wr_delay;
          wr_state_d = W_BEAT;
        end
      end
      W_BEAT: begin
        sram_we = 1'b1;
        wr_adv  = 1'b1;
        if (wr_last) begin
          wr_state_d = W_IDLE;
        end else if (wr_delay_q != '0) begin
          wr_gap_d   = wr_delay_q;
          wr_state_d = W_GAP;
        end
      end
      W_GAP: begin
        wr_gap_d = wr_gap_q - CNT_WIDTH'(1);
        if (wr_gap_q == CNT_WIDTH'(1)) wr_state_d = W_BEAT;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Drain channel next-state: read, present until accepted, optional gap.
  always_comb begin
    dr_state_d = dr_state_q;
    dr_delay_d = dr_delay_q;
    dr_gap_d   = dr_gap_q;
    dr_load    = 1'b0;
    dr_adv     = 1'b0;
    sram_re    = 1'b0;
    case (dr_state_q)
      D_IDLE: begin
        if (activate[PORT_RD]) begin
          dr_load    = 1'b1;
          dr_delay_d = cfg_q.rd_delay;
          dr_state_d = D_RD;
        end
      end
      D_RD: begin
        sram_re    = 1'b1;
        dr_state_d = D_XFER;
      end
      D_XFER: begin
        if (io_ready_out) begin
          dr_adv = 1'b1;
          if (dr_last) begin
            dr_state_d = D_IDLE;
          end else if (dr_delay_q != '0) begin
            dr_gap_d   = dr_delay_q;
            dr_state_d = D_GAP;
          end else begin
            dr_state_d = D_RD;
          end
        end
      end
      D_GAP: begin
        dr_gap_d = dr_gap_q - CNT_WIDTH'(1);
        if (dr_gap_q == CNT_WIDTH'(1)) dr_state_d = D_RD;
      end
      default: dr_state_d = D_IDLE;
    endcase
  end

  // Read register captures the pre-write word, giving read-before-write.
  always_comb begin
    rdata_d = rdata_q;
    if (sram_re) rdata_d = mem_q[rd_addr];
  end

  // Control and config registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q      <= '0;
      wr_state_q <= W_IDLE;
      wr_delay_q <= '0;
      wr_gap_q   <= '0;
      dr_state_q <= D_IDLE;
      dr_delay_q <= '0;
      dr_gap_q   <= '0;
      rdata_q    <= '0;
    end else begin
      cfg_q      <= cfg_d;
      wr_state_q <= wr_state_d;
      wr_delay_q <= wr_delay_d;
      wr_gap_q   <= wr_gap_d;
      dr_state_q <= dr_state_d;
      dr_delay_q <= dr_delay_d;
      dr_gap_q   <= dr_gap_d;
      rdata_q    <= rdata_d;
    end
  end

  // Buffer storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (sram_we) mem_q[wr_addr] <= bulk_data_in;
  end

  iosram_out_agu #(.W(SRAM_ADDR_WIDTH), .CW(CNT_WIDTH)) u_wr_agu (
    .clk     (clk),
    .rst     (rst),
    .load    (wr_load),
    .advance (wr_adv),
    .init    (cfg_q.wr_init),
    .step    (cfg_q.wr_step),
    .iter    (cfg_q.wr_iter),
    .addr    (wr_addr),
    .last    (wr_last)
  );

  iosram_out_agu #(.W(SRAM_ADDR_WIDTH), .CW(CNT_WIDTH)) u_rd_agu (
    .clk     (clk),
    .rst     (rst),
    .load    (dr_load),
    .advance (dr_adv),
    .init    (cfg_q.rd_init),
    .step    (cfg_q.rd_step),
    .iter    (cfg_q.rd_iter),
    .addr    (rd_addr),
    .last    (rd_last)
  );

  // IO address runs in lockstep with the SRAM read address, same beat count.
  iosram_out_agu #(.W(IO_ADDR_WIDTH), .CW(CNT_WIDTH)) u_io_agu (
    .clk     (clk),
    .rst     (rst),
    .load    (dr_load),
    .advance (dr_adv),
    .init    (cfg_q.io_init),
    .step    ({{(IO_ADDR_WIDTH-CNT_WIDTH){1'b0}}, cfg_q.io_step}),
    .iter    (cfg_q.rd_iter),
    .addr    (io_addr),
    .last    (io_last)
  );

  assign dr_last     = rd_last & io_last;
  assign io_en_out   = (dr_state_q == D_XFER);
  assign io_addr_out = io_en_out ? io_addr : '0;
  assign io_data_out = io_en_out ? rdata_q : '0;
  assign busy        = {dr_state_q != D_IDLE, wr_state_q != W_IDLE};

endmodule

// File: tb/tb_iosram_out_sequencer.sv
// Scoreboard bench: stimulus pushes expected IO beats, monitor pops on accept.
module tb_iosram_out_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         instr_en;
  logic [26:0]  instr;
  logic [3:0]   activate;
  logic [255:0] bulk_data_in;
  logic         io_en_out;
  logic [15:0]  io_addr_out;
  logic [255:0] io_data_out;
  logic         io_ready_out;
  logic [1:0]   busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0]  addr;
    logic [255:0] data;
  } beat_t;
  beat_t exp_q[$];

  iosram_out_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .instr_en     (instr_en),
    .instr        (instr),
    .activate     (activate),
    .bulk_data_in (bulk_data_in),
    .io_en_out    (io_en_out),
    .io_addr_out  (io_addr_out),
    .io_data_out  (io_data_out),
    .io_ready_out (io_ready_out),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] dpat(input logic [7:0] x);
    return {32{x}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [23:0] payload);
    instr    = {op, payload};
    instr_en = 1'b1;
    tick();
    instr_en = 1'b0;
    instr    = '0;
  endtask

  task automatic dsu(input logic [1:0] port, input logic [15:0] init);
    send(3'd6, {1'b0, init, port, 5'b0});
  endtask

  task automatic rep(input logic [1:0] port, input logic [3:0] level, input logic [5:0] iter,
                     input logic [5:0] step, input logic [5:0] delay);
    send(3'd0, {port, level, iter, step, delay});
  endtask

  task automatic act(input logic [3:0] mask);
    activate = mask;
    tick();
    activate = 4'b0;
  endtask

  task automatic push(input logic [15:0] addr, input logic [255:0] data);
    beat_t b;
    b.addr = addr;
    b.data = data;
    exp_q.push_back(b);
  endtask

  // Runs a drain that is busy for ncyc cycles, checking io_en per cycle.
  task automatic run_drain(input int ncyc, input logic [15:0] en_mask, input int stall_from,
                           input int stall_to, input int react_at);
    for (int c = 0; c < ncyc; c++) begin
      io_ready_out = !(c >= stall_from && c <= stall_to);
      activate     = (c == react_at) ? 4'b1000 : 4'b0000;
      chk("drain_busy", busy[1], 1'b1);
      chk("drain_io_en", io_en_out, en_mask[c]);
      tick();
    end
    activate     = 4'b0;
    io_ready_out = 1'b1;
    chk("drain_done_busy", busy[1], 1'b0);
    chk("drain_done_io_en", io_en_out, 1'b0);
  endtask

  // Monitor: stall hold check and scoreboard pop on accepted beats.
  logic         prev_stall = 1'b0;
  logic [15:0]  prev_addr  = '0;
  logic [255:0] prev_data  = '0;
  always @(negedge clk) begin
    beat_t b;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_en", io_en_out, 1'b1);
        chk("hold_addr", io_addr_out, prev_addr);
        chk("hold_data", io_data_out, prev_data);
      end
      if (io_en_out && io_ready_out) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got addr %0h, expected no beat", io_addr_out);
        end else begin
          b = exp_q.pop_front();
          chk("beat_addr", io_addr_out, b.addr);
          chk("beat_data", io_data_out, b.data);
        end
      end
      prev_stall = io_en_out && !io_ready_out;
      prev_addr  = io_addr_out;
      prev_data  = io_data_out;
    end
  end

  initial begin
    rst = 1'b1; instr_en = 1'b0; instr = '0; activate = '0;
    bulk_data_in = '0; io_ready_out = 1'b1;
    repeat (3) tick();
    chk("rst_io_en", io_en_out, 1'b0);
    chk("rst_io_addr", io_addr_out, 16'h0);
    chk("rst_io_data", io_data_out, 256'h0);
    chk("rst_busy", busy, 2'b00);
    rst = 1'b0;
    tick();

    // Write A0..A3 to addresses 4..7.
    dsu(2'd2, 16'd4);
    rep(2'd2, 4'd0, 6'd3, 6'd1, 6'd0);
    act(4'b0100);
    for (int c = 0; c < 4; c++) begin
      bulk_data_in = dpat(8'(8'hA0 + c));
      chk("wr_busy", busy[0], 1'b1);
      tick();
    end
    chk("wr_done_busy", busy[0], 1'b0);

    // Drain 4..7 to IO 0x1000 step 2.
    dsu(2'd3, 16'd4);
    rep(2'd3, 4'd0, 6'd3, 6'd1, 6'd0);
    dsu(2'd0, 16'h1000);
    rep(2'd0, 4'd0, 6'd0, 6'd2, 6'd0);
    for (int k = 0; k < 4; k++) push(16'(16'h1000 + 2 * k), dpat(8'(8'hA0 + k)));
    act(4'b1000);
    run_drain(8, 16'b1010_1010, -1, -2, -1);

    // Backpressure on beat 1 for 5 cycles.
    for (int k = 0; k < 4; k++) push(16'(16'h1000 + 2 * k), dpat(8'(8'hA0 + k)));
    act(4'b1000);
    run_drain(13, 16'h15FA, 3, 7, -1);

    // Reset during D_XFER of beat 2.
    push(16'h1000, dpat(8'hA0));
    push(16'h1002, dpat(8'hA1));
    act(4'b1000);
    for (int c = 0; c < 5; c++) tick();
    chk("pre_rst_io_en", io_en_out, 1'b1);
    rst = 1'b1;
    tick();
    chk("midrst_io_en", io_en_out, 1'b0);
    chk("midrst_io_addr", io_addr_out, 16'h0);
    chk("midrst_io_data", io_data_out, 256'h0);
    chk("midrst_busy", busy, 2'b00);
    rst = 1'b0;
    tick();

    // Reload and restart from beat 0.
    dsu(2'd3, 16'd4);
    rep(2'd3, 4'd0, 6'd3, 6'd1, 6'd0);
    dsu(2'd0, 16'h1000);
    rep(2'd0, 4'd0, 6'd0, 6'd2, 6'd0);
    for (int k = 0; k < 4; k++) push(16'(16'h1000 + 2 * k), dpat(8'(8'hA0 + k)));
    act(4'b1000);
    run_drain(8, 16'b1010_1010, -1, -2, -1);

    // Ignored: REP level 1, opcode 1, activate while busy.
    rep(2'd3, 4'd1, 6'd0, 6'd5, 6'd2);
    send(3'd1, {2'd3, 4'd0, 6'd0, 6'd7, 6'd0});
    for (int k = 0; k < 4; k++) push(16'(16'h1000 + 2 * k), dpat(8'(8'hA0 + k)));
    act(4'b1000);
    run_drain(8, 16'b1010_1010, -1, -2, 2);

    // Delay and wrap: writes at 62, 63, 0 with 3-cycle gaps.
    dsu(2'd2, 16'd62);
    rep(2'd2, 4'd0, 6'd2, 6'd1, 6'd3);
    act(4'b0100);
    for (int c = 0; c < 10; c++) begin
      bulk_data_in = dpat(8'(8'hB0 + c));
      chk("wr_gap_busy", busy[0], (c < 9) ? 1'b1 : 1'b0);
      tick();
    end
    dsu(2'd3, 16'd62);
    rep(2'd3, 4'd0, 6'd2, 6'd1, 6'd2);
    dsu(2'd0, 16'hFFFF);
    rep(2'd0, 4'd0, 6'd0, 6'd1, 6'd0);
    push(16'hFFFF, dpat(8'hB0));
    push(16'h0000, dpat(8'hB4));
    push(16'h0001, dpat(8'hB8));
    act(4'b1000);
    run_drain(10, 16'h0222, -1, -2, -1);

    // Read-before-write at address 10.
    dsu(2'd2, 16'd10);
    rep(2'd2, 4'd0, 6'd0, 6'd0, 6'd0);
    bulk_data_in = dpat(8'h55);
    act(4'b0100);
    chk("wr55_busy", busy[0], 1'b1);
    tick();
    chk("wr55_done", busy[0], 1'b0);
    dsu(2'd3, 16'd10);
    rep(2'd3, 4'd0, 6'd0, 6'd0, 6'd0);
    dsu(2'd0, 16'h2000);
    rep(2'd0, 4'd0, 6'd0, 6'd0, 6'd0);
    bulk_data_in = dpat(8'h77);
    push(16'h2000, dpat(8'h55));
    act(4'b1100);
    run_drain(2, 16'b10, -1, -2, -1);
    chk("rbw_wr_done", busy[0], 1'b0);
    rep(2'd3, 4'd0, 6'd1, 6'd0, 6'd0);
    push(16'h2000, dpat(8'h77));
    push(16'h2000, dpat(8'h77));
    act(4'b1000);
    run_drain(4, 16'b1010, -1, -2, -1);

    tick();
    chk("queue_empty", 256'(exp_q.size()), 256'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

endmodule
